// File: rtl/jkff_bank_multimode.sv
// jkff_bank_multimode: WIDTH-bit bank of flip-flops whose shared mode selects
// HOLD / D / T / JK / SR behaviour, or up/down counting built from per-bit
// toggle enables. Provides a wrap pulse for counter roll-over and a sticky
// error flag for illegal SR inputs or the reserved mode.
module jkff_bank_multimode #(
    parameter int unsigned          WIDTH   = 4,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             wrap,
    output logic             err
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_D    = 3'd1,
        MODE_T    = 3'd2,
        MODE_JK   = 3'd3,
        MODE_SR   = 3'd4,
        MODE_UP   = 3'd5,
        MODE_DOWN = 3'd6,
        MODE_RSVD = 3'd7
    } mode_t;

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] mask_lo;
    logic             wrap_next;
    logic             err_set;

    // Per-bit toggle enables for the counter: bit i toggles when all lower
    // bits are 1 (up) or all lower bits are 0 (down). Computed from a
    // low-bit mask per position rather than a self-referencing chain vector.
    always_comb begin
        up_t    = '0;
        dn_t    = '0;
        mask_lo = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            mask_lo = (WIDTH'(1) << i) - WIDTH'(1);
            up_t[i] = &(q | ~mask_lo);
            dn_t[i] = ~|(q & mask_lo);
        end
    end

    // Next-state, wrap and error detection for the selected mode.
    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        err_set   = 1'b0;
        case (mode_t'(mode))
            MODE_HOLD: q_next = q;
            MODE_D:    q_next = j;
            MODE_T:    q_next = q ^ j;
            MODE_JK: begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    case ({j[i], k[i]})
                        2'b01:   q_next[i] = 1'b0;
                        2'b10:   q_next[i] = 1'b1;
                        2'b11:   q_next[i] = ~q[i];
                        default: q_next[i] = q[i];
                    endcase
                end
            end
            MODE_SR: begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    case ({j[i], k[i]})
                        2'b01:   q_next[i] = 1'b0;
                        2'b10:   q_next[i] = 1'b1;
                        2'b11:   err_set   = 1'b1;
                        default: q_next[i] = q[i];
                    endcase
                end
            end
            MODE_UP: begin
                q_next    = q ^ up_t;
                wrap_next = &q;
            end
            MODE_DOWN: begin
                q_next    = q ^ dn_t;
                wrap_next = ~|q;
            end
            MODE_RSVD: err_set = 1'b1;
        endcase
    end

    // State register: q, wrap pulse and sticky err; a new error beats clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= RST_VAL;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else if (en) begin
            q    <= q_next;
            wrap <= wrap_next;
            if (err_set)
                err <= 1'b1;
            else if (clr_err)
                err <= 1'b0;
        end else begin
            wrap <= 1'b0;
        end
    end

    // Complement output follows q with no register stage.
    always_comb begin
        qbar = ~q;
    end

endmodule

// File: tb/tb_jkff_bank_multimode.sv
// tb_jkff_bank_multimode: directed scenarios with literal expectations plus a
// randomized run, all checked against an arithmetic reference model.
module tb_jkff_bank_multimode;

    localparam int unsigned W    = 4;
    localparam int unsigned MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         clr_err;
    logic [W-1:0] q;
    logic [W-1:0] qbar;
    logic         wrap;
    logic         err;

    int checks = 0;
    int errors = 0;

    // reference model state
    int unsigned m_q;
    bit          m_wrap;
    bit          m_err;

    jkff_bank_multimode #(.WIDTH(W), .RST_VAL(4'h0)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .j       (j),
        .k       (k),
        .clr_err (clr_err),
        .q       (q),
        .qbar    (qbar),
        .wrap    (wrap),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: next state from the mode rules using plain arithmetic.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q    = 0;
            m_wrap = 0;
            m_err  = 0;
        end else if (en) begin
            int unsigned nq;
            bit          bad;
            bit          nw;
            nq  = m_q;
            bad = 0;
            nw  = 0;
            case (mode)
                3'd1: nq = j;
                3'd2: nq = m_q ^ j;
                3'd3, 3'd4: begin
                    for (int b = 0; b < W; b++) begin
                        int unsigned jb, kb, cur;
                        jb  = (j >> b) & 1;
                        kb  = (k >> b) & 1;
                        cur = (m_q >> b) & 1;
                        if (jb == 1 && kb == 0) cur = 1;
                        else if (jb == 0 && kb == 1) cur = 0;
                        else if (jb == 1 && kb == 1) begin
                            if (mode == 3'd3) cur = 1 - cur;
                            else bad = 1;
                        end
                        nq = (nq & ~(1 << b)) | (cur << b);
                    end
                end
                3'd5: begin nq = (m_q + 1) % (MASK + 1); nw = (m_q == MASK); end
                3'd6: begin nq = (m_q + MASK) % (MASK + 1); nw = (m_q == 0); end
                3'd7: bad = 1;
                default: nq = m_q;
            endcase
            m_q    = nq;
            m_wrap = nw;
            if (bad) m_err = 1;
            else if (clr_err) m_err = 0;
        end else begin
            m_wrap = 0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("cyc_q", q, m_q);
        chk("cyc_qbar", qbar, (~m_q) & MASK);
        chk("cyc_wrap", wrap, m_wrap);
        chk("cyc_err", err, m_err);
    end

    task automatic step(input logic e, input logic [2:0] m, input logic [W-1:0] jj,
                        input logic [W-1:0] kk, input logic c);
        en = e; mode = m; j = jj; k = kk; clr_err = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 3'd0; j = '0; k = '0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q", q, 4'h0);
        chk("rst_qbar", qbar, 4'hF);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;

        // 1. async reset mid-count
        step(1'b1, 3'd1, 4'h7, 4'h0, 1'b0);
        chk("load7", q, 4'h7);
        mode = 3'd5;
        #2 rst = 1'b1;
        #1;
        chk("midrst_q", q, 4'h0);
        chk("midrst_qbar", qbar, 4'hF);
        chk("midrst_wrap", wrap, 1'b0);
        chk("midrst_err", err, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("resume_q", q, 4'h1);

        // 2. JK: bit3 toggle, bit2 set, bit1 reset, bit0 hold
        step(1'b1, 3'd1, 4'h0, 4'h0, 1'b0);
        step(1'b1, 3'd3, 4'b1100, 4'b1010, 1'b0);
        chk("jk1", q, 4'b1100);
        step(1'b1, 3'd3, 4'b1100, 4'b1010, 1'b0);
        chk("jk2", q, 4'b0100);

        // 3. up/down wrap
        step(1'b1, 3'd1, 4'hE, 4'h0, 1'b0);
        step(1'b1, 3'd5, 4'h0, 4'h0, 1'b0);
        chk("up_F", q, 4'hF); chk("up_F_wrap", wrap, 1'b0);
        step(1'b1, 3'd5, 4'h0, 4'h0, 1'b0);
        chk("up_0", q, 4'h0); chk("up_0_wrap", wrap, 1'b1);
        step(1'b1, 3'd5, 4'h0, 4'h0, 1'b0);
        chk("up_1", q, 4'h1); chk("up_1_wrap", wrap, 1'b0);
        step(1'b1, 3'd6, 4'h0, 4'h0, 1'b0);
        chk("dn_0", q, 4'h0); chk("dn_0_wrap", wrap, 1'b0);
        step(1'b1, 3'd6, 4'h0, 4'h0, 1'b0);
        chk("dn_F", q, 4'hF); chk("dn_F_wrap", wrap, 1'b1);

        // 4. SR illegal bit holds, sticky err and clear priority
        step(1'b1, 3'd1, 4'b0101, 4'h0, 1'b0);
        step(1'b1, 3'd4, 4'b0011, 4'b0001, 1'b0);
        chk("sr_q", q, 4'b0111); chk("sr_err", err, 1'b1);
        step(1'b1, 3'd1, 4'h5, 4'h0, 1'b1);
        chk("clr_err", err, 1'b0);
        step(1'b1, 3'd7, 4'hA, 4'hA, 1'b0);
        chk("rsvd_err", err, 1'b1); chk("rsvd_q", q, 4'h5);
        step(1'b1, 3'd7, 4'hA, 4'hA, 1'b1);
        chk("rsvd_clr_err", err, 1'b1); chk("rsvd_clr_q", q, 4'h5);

        // 5. enable, T, D
        step(1'b1, 3'd1, 4'hA, 4'h0, 1'b0);
        repeat (5) begin
            step(1'b0, 3'd5, 4'h0, 4'h0, 1'b0);
            chk("en0_q", q, 4'hA); chk("en0_wrap", wrap, 1'b0);
        end
        step(1'b1, 3'd2, 4'hF, 4'h0, 1'b0);
        chk("t_q", q, 4'h5);
        step(1'b1, 3'd1, 4'h3, 4'h0, 1'b0);
        chk("d_q", q, 4'h3);

        // 6. randomized run, occasional mid-cycle async reset
        for (int n = 0; n < 3000; n++) begin
            en      = ($urandom_range(0, 7) != 0);
            mode    = 3'($urandom_range(0, 7));
            j       = W'($urandom);
            k       = W'($urandom);
            clr_err = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
